// File: rtl/noc_pkg.sv
// noc_pkg: shared definitions for the buffered XY mesh router.
//   - port index constants (N, S, E, W, PE) and the port count
//   - route-direction encoding used by the routing logic
//   - flit field offset helpers
//     flit layout: {x_dest, y_dest, payload}, with x_dest in the MSBs
package noc_pkg;

    localparam int PORT_N    = 0;
    localparam int PORT_S    = 1;
    localparam int PORT_E    = 2;
    localparam int PORT_W    = 3;
    localparam int PORT_PE   = 4;
    localparam int NUM_PORTS = 5;

    typedef enum logic [2:0] {
        DIR_N  = 3'd0,
        DIR_S  = 3'd1,
        DIR_E  = 3'd2,
        DIR_W  = 3'd3,
        DIR_PE = 3'd4
    } route_dir_e;

    // LSB position of y_dest inside a flit
    function automatic int y_dest_off(input int data_width);
        return data_width;
    endfunction

    // LSB position of x_dest inside a flit
    function automatic int x_dest_off(input int data_width, input int addr_width);
        return data_width + addr_width;
    endfunction

endpackage

// File: rtl/router_input_fifo.sv
// router_input_fifo: per-input flit buffer for the mesh router.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   push, push_data   write request and flit (caller only pushes when !full)
//   pop               read request (ignored when empty)
//   full, empty       derived from the registered occupancy counter
//   head              flit at the read pointer, valid while !empty
module router_input_fifo #(
    parameter int FLIT_W     = 20,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [FLIT_W-1:0] push_data,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [FLIT_W-1:0] head
);
    localparam int PW = $clog2(FIFO_DEPTH);

    logic [FLIT_W-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW:0]       count;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (count == (PW+1)'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Storage has no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/buffered_xy_router.sv
// buffered_xy_router: 5-port mesh router tile with per-input FIFOs,
// deterministic XY routing of single-flit packets and per-output
// round-robin arbitration. Port index: 0=N 1=S 2=E 3=W 4=PE.
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   i_valid/i_data     input flits, port k at [k*FLIT_W +: FLIT_W]
//   i_ready            input accept (FIFO not full)
//   o_valid/o_data     registered output flits
//   o_ready            downstream accept
//   o_drop             pulse when an out-of-mesh head flit is discarded
// Optional build macro ROUTER_STATS_EN adds o_flit_cnt (16 bits per output,
// saturating count of o_valid&o_ready) and o_drop_cnt (saturating).
module buffered_xy_router
    import noc_pkg::*;
#(
    parameter  int DATA_WIDTH = 16,
    parameter  int ADDR_WIDTH = 2,
    parameter  int MESH_SIZE  = 4,
    parameter  int X_cord     = 0,
    parameter  int Y_cord     = 0,
    parameter  int FIFO_DEPTH = 4,
    localparam int FLIT_W     = DATA_WIDTH + 2*ADDR_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_PORTS-1:0]          i_valid,
    input  logic [NUM_PORTS*FLIT_W-1:0]   i_data,
    output logic [NUM_PORTS-1:0]          i_ready,
    output logic [NUM_PORTS-1:0]          o_valid,
    output logic [NUM_PORTS*FLIT_W-1:0]   o_data,
    input  logic [NUM_PORTS-1:0]          o_ready,
`ifdef ROUTER_STATS_EN
    output logic [NUM_PORTS*16-1:0]       o_flit_cnt,
    output logic [15:0]                   o_drop_cnt,
`endif
    output logic                          o_drop
);
    localparam int XO = x_dest_off(DATA_WIDTH, ADDR_WIDTH);
    localparam int YO = y_dest_off(DATA_WIDTH);

    logic [NUM_PORTS-1:0] fifo_full;
    logic [NUM_PORTS-1:0] fifo_empty;
    logic [NUM_PORTS-1:0] pop;
    logic [NUM_PORTS-1:0] drop;
    logic [FLIT_W-1:0]    head      [NUM_PORTS];
    route_dir_e           route_dir [NUM_PORTS];
    logic [NUM_PORTS-1:0] req       [NUM_PORTS];   // req[output][input]
    logic [NUM_PORTS-1:0] grant_vld;
    logic [2:0]           grant_idx [NUM_PORTS];
    logic [2:0]           rr_ptr    [NUM_PORTS];
    logic [NUM_PORTS-1:0] can_load;

    // Held low during reset so nothing is pushed while state is being cleared.
    assign i_ready  = rst_n ? ~fifo_full : '0;
    assign can_load = ~o_valid | o_ready;
    assign o_drop   = rst_n && (|drop);

    for (genvar k = 0; k < NUM_PORTS; k++) begin : g_fifo
        router_input_fifo #(
            .FLIT_W     (FLIT_W),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst_n     (rst_n),
            .push      (i_valid[k] && i_ready[k]),
            .push_data (i_data[k*FLIT_W +: FLIT_W]),
            .pop       (pop[k]),
            .full      (fifo_full[k]),
            .empty     (fifo_empty[k]),
            .head      (head[k])
        );
    end

    always_comb begin
        for (int k = 0; k < NUM_PORTS; k++) begin
            logic [ADDR_WIDTH-1:0] xd;
            logic [ADDR_WIDTH-1:0] yd;
            xd = head[k][XO +: ADDR_WIDTH];
            yd = head[k][YO +: ADDR_WIDTH];
            drop[k] = !fifo_empty[k] &&
                      (int'(xd) >= MESH_SIZE || int'(yd) >= MESH_SIZE);
            if      (int'(xd) > X_cord) route_dir[k] = DIR_E;
            else if (int'(xd) < X_cord) route_dir[k] = DIR_W;
            else if (int'(yd) > Y_cord) route_dir[k] = DIR_N;
            else if (int'(yd) < Y_cord) route_dir[k] = DIR_S;
            else                        route_dir[k] = DIR_PE;
        end
    end

    // Round-robin: scan ptr+1 .. ptr+5 (mod 5), first requester wins.
    always_comb begin
        for (int o = 0; o < NUM_PORTS; o++) begin
            req[o]       = '0;
            grant_vld[o] = 1'b0;
            grant_idx[o] = '0;
            for (int k = 0; k < NUM_PORTS; k++) begin
                req[o][k] = !fifo_empty[k] && !drop[k] && (int'(route_dir[k]) == o);
            end
            for (int off = 1; off <= NUM_PORTS; off++) begin
                int idx;
                idx = (int'(rr_ptr[o]) + off) % NUM_PORTS;
                if (!grant_vld[o] && can_load[o] && req[o][idx]) begin
                    grant_vld[o] = 1'b1;
                    grant_idx[o] = 3'(idx);
                end
            end
        end
    end

    // Each head routes to exactly one output, so at most one grant per input.
    always_comb begin
        pop = drop;
        for (int o = 0; o < NUM_PORTS; o++) begin
            if (grant_vld[o]) pop[grant_idx[o]] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_valid <= '0;
            o_data  <= '0;
            for (int o = 0; o < NUM_PORTS; o++) rr_ptr[o] <= 3'd4;
        end else begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                if (grant_vld[o]) begin
                    o_valid[o]                  <= 1'b1;
                    o_data[o*FLIT_W +: FLIT_W]  <= head[grant_idx[o]];
                    rr_ptr[o]                   <= grant_idx[o];
                end else if (o_ready[o]) begin
                    o_valid[o] <= 1'b0;
                end
            end
        end
    end

`ifdef ROUTER_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_flit_cnt <= '0;
            o_drop_cnt <= '0;
        end else begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                if (o_valid[o] && o_ready[o] && o_flit_cnt[o*16 +: 16] != 16'hFFFF)
                    o_flit_cnt[o*16 +: 16] <= o_flit_cnt[o*16 +: 16] + 16'd1;
            end
            if (o_drop && o_drop_cnt != 16'hFFFF)
                o_drop_cnt <= o_drop_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_buffered_xy_router.sv
// tb_buffered_xy_router: directed-vector bench for buffered_xy_router at
// node (1,1) of a 4x4 mesh, plus a 3x3-mesh instance for the drop path.
module tb_buffered_xy_router;
    localparam int DW = 16;
    localparam int AW = 2;
    localparam int FW = DW + 2*AW;
    localparam int NP = 5;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NP-1:0]   i_valid, i_ready, o_valid, o_ready;
    logic [NP*FW-1:0] i_data, o_data;
    logic            o_drop;
    logic [NP-1:0]   i_valid3, i_ready3, o_valid3, o_ready3;
    logic [NP*FW-1:0] i_data3, o_data3;
    logic            o_drop3;
`ifdef ROUTER_STATS_EN
    logic [NP*16-1:0] o_flit_cnt, o_flit_cnt3;
    logic [15:0]      o_drop_cnt, o_drop_cnt3;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    buffered_xy_router #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MESH_SIZE(4),
                         .X_cord(1), .Y_cord(1), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_data(i_data),
        .i_ready(i_ready), .o_valid(o_valid), .o_data(o_data), .o_ready(o_ready),
`ifdef ROUTER_STATS_EN
        .o_flit_cnt(o_flit_cnt), .o_drop_cnt(o_drop_cnt),
`endif
        .o_drop(o_drop));

    buffered_xy_router #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MESH_SIZE(3),
                         .X_cord(1), .Y_cord(1), .FIFO_DEPTH(4)) dut3 (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid3), .i_data(i_data3),
        .i_ready(i_ready3), .o_valid(o_valid3), .o_data(o_data3), .o_ready(o_ready3),
`ifdef ROUTER_STATS_EN
        .o_flit_cnt(o_flit_cnt3), .o_drop_cnt(o_drop_cnt3),
`endif
        .o_drop(o_drop3));

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // advance one clock, leave time 1 unit past the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [FW-1:0] mk(input int x, input int y, input logic [DW-1:0] p);
        logic [AW-1:0] xa, ya;
        xa = AW'(x);
        ya = AW'(y);
        return {xa, ya, p};
    endfunction

    function automatic logic [FW-1:0] out_flit(input int k);
        return o_data[k*FW +: FW];
    endfunction

    task automatic send(input int k, input logic [FW-1:0] f);
        i_valid[k]         = 1'b1;
        i_data[k*FW +: FW] = f;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [FW-1:0] fl [6];
        rst_n = 1'b0;
        i_valid = '0; i_data = '0; o_ready = '1;
        i_valid3 = '0; i_data3 = '0; o_ready3 = '1;
        step(); step();

        // reset state
        check_val("rst_o_valid", 32'(o_valid), 32'h0);
        check_val("rst_i_ready", 32'(i_ready), 32'h0);
        check_val("rst_o_drop",  32'(o_drop),  32'h0);
        check_val("rst_o_data_pe", 32'(out_flit(4)), 32'h0);
        rst_n = 1'b1;
        #1;
        check_val("post_rst_i_ready", 32'(i_ready), 32'h1f);

        // PE -> E, two-cycle latency
        send(4, mk(2, 1, 16'hAAAA));
        step();
        i_valid = '0;
        check_val("lat_edge0_o_valid", 32'(o_valid), 32'h0);
        step();
        check_val("lat_edge1_o_valid", 32'(o_valid), 32'h04);
        check_val("lat_edge1_o_data_e", 32'(out_flit(2)), 32'(mk(2, 1, 16'hAAAA)));
        step();
        check_val("lat_drain_o_valid", 32'(o_valid), 32'h0);

        // N, S, W -> PE simultaneously: round-robin from ptr=4 gives N, S, W
        send(0, mk(1, 1, 16'h1110));
        send(1, mk(1, 1, 16'h1111));
        send(3, mk(1, 1, 16'h1113));
        step();
        i_valid = '0;
        step();
        check_val("rr0_o_valid", 32'(o_valid), 32'h10);
        check_val("rr0_data_n", 32'(out_flit(4)), 32'(mk(1, 1, 16'h1110)));
        step();
        check_val("rr1_o_valid", 32'(o_valid), 32'h10);
        check_val("rr1_data_s", 32'(out_flit(4)), 32'(mk(1, 1, 16'h1111)));
        step();
        check_val("rr2_o_valid", 32'(o_valid), 32'h10);
        check_val("rr2_data_w", 32'(out_flit(4)), 32'(mk(1, 1, 16'h1113)));
        step();
        check_val("rr_drain_o_valid", 32'(o_valid), 32'h0);

        // backpressure on W: 6 attempts from E, the 6th is refused
        o_ready = 5'b10111;
        for (int k = 0; k < 6; k++) begin
            fl[k] = mk(0, 1, 16'h0500 + 16'(k));
            send(2, fl[k]);
            #1;
            check_val($sformatf("bp_i_ready_%0d", k), 32'(i_ready[2]), (k < 5) ? 32'h1 : 32'h0);
            step();
        end
        i_valid = '0;
        check_val("bp_hold_o_valid", 32'(o_valid), 32'h08);
        check_val("bp_hold_data", 32'(out_flit(3)), 32'(fl[0]));
        step();
        check_val("bp_stable_data", 32'(out_flit(3)), 32'(fl[0]));
        o_ready = '1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check_val($sformatf("bp_rel_valid_%0d", k), 32'(o_valid), 32'h08);
            check_val($sformatf("bp_rel_data_%0d", k), 32'(out_flit(3)), 32'(fl[k]));
            step();
        end
        check_val("bp_rel_empty", 32'(o_valid), 32'h0);

        // routing from input E
        send(2, mk(3, 0, 16'h1234));
        step(); i_valid = '0; step();
        check_val("route_e_valid", 32'(o_valid), 32'h04);
        check_val("route_e_data", 32'(out_flit(2)), 32'(mk(3, 0, 16'h1234)));
        send(2, mk(1, 3, 16'h5678));
        step(); i_valid = '0; step();
        check_val("route_n_valid", 32'(o_valid), 32'h01);
        check_val("route_n_data", 32'(out_flit(0)), 32'(mk(1, 3, 16'h5678)));
        send(2, mk(1, 0, 16'h9ABC));
        step(); i_valid = '0; step();
        check_val("route_s_valid", 32'(o_valid), 32'h02);
        check_val("route_s_data", 32'(out_flit(1)), 32'(mk(1, 0, 16'h9ABC)));
        step();

        // out-of-mesh flit on the 3x3 instance
        check_val("drop_idle", 32'(o_drop3), 32'h0);
        i_valid3[4]          = 1'b1;
        i_data3[4*FW +: FW]  = mk(3, 1, 16'hDEAD);
        step();
        i_valid3 = '0;
        check_val("drop_pulse", 32'(o_drop3), 32'h1);
        check_val("drop_no_valid0", 32'(o_valid3), 32'h0);
        step();
        check_val("drop_end", 32'(o_drop3), 32'h0);
        check_val("drop_no_valid1", 32'(o_valid3), 32'h0);

        // mid-operation reset with flits buffered
        o_ready = 5'b01111;
        send(0, mk(1, 1, 16'hC000));
        send(1, mk(1, 1, 16'hC001));
        send(2, mk(1, 1, 16'hC002));
        step(); i_valid = '0; step();
        check_val("mid_pre_valid", 32'(o_valid), 32'h10);
        rst_n = 1'b0;
        step();
        check_val("mid_rst_valid", 32'(o_valid), 32'h0);
        check_val("mid_rst_i_ready", 32'(i_ready), 32'h0);
        check_val("mid_rst_data", 32'(out_flit(4)), 32'h0);
        rst_n = 1'b1;
        o_ready = '1;
        #1;
        check_val("mid_rel_i_ready", 32'(i_ready), 32'h1f);
        for (int k = 0; k < 4; k++) begin
            step();
            check_val($sformatf("mid_no_stale_%0d", k), 32'(o_valid), 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/buffered_xy_router.md
Name: buffered_xy_router

Overview:
- Next-generation 5-port mesh router tile: per-input FIFO buffering, valid/ready backpressure on every port, per-output round-robin arbitration.
- Deterministic XY routing of single-flit packets; instantiated once per mesh node at (X_cord, Y_cord).
- Replaces the unbuffered router, which drops traffic on contention.

Parameters:
- DATA_WIDTH, 16, payload bits per flit
- ADDR_WIDTH, 2, bits per coordinate
- MESH_SIZE, 4, mesh is MESH_SIZE x MESH_SIZE; coordinates 0..MESH_SIZE-1
- X_cord, 0, this node's X coordinate
- Y_cord, 0, this node's Y coordinate
- FIFO_DEPTH, 4, entries per input FIFO; power of two, >=2
- FLIT_W (localparam), DATA_WIDTH+2*ADDR_WIDTH, flit width

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous reset, active-low
- i_valid  in  5  per-input flit valid; index 0=N 1=S 2=E 3=W 4=PE
- i_data  in  5*FLIT_W  input flits; port k at [k*FLIT_W +: FLIT_W]
- i_ready  out  5  per-input accept
- o_valid  out  5  per-output flit valid, same indexing
- o_data  out  5*FLIT_W  output flits
- o_ready  in  5  downstream accept
- o_drop  out  1  one-cycle pulse when an out-of-mesh flit is discarded

Behaviour:
- Interface: one clock, reset synchronous and active-low (clk, rst_n).
- Flit format: {x_dest[ADDR_WIDTH-1:0], y_dest[ADDR_WIDTH-1:0], payload[DATA_WIDTH-1:0]}, x_dest in MSBs.
- Reset (rst_n=0 at a clock edge): FIFOs emptied, o_valid=0, o_data=0, i_ready=0 during reset, o_drop=0, all RR pointers=4 so input 0 has first priority. Mid-operation reset discards all buffered and output-register flits in that cycle.
- Input handshake: transfer when i_valid&i_ready. i_ready[k] = FIFO k not full (registered occupancy). When full, i_ready=0 even if a pop occurs that cycle.
- Routing of FIFO head (combinational):
  - x_dest>X_cord -> E; x_dest<X_cord -> W.
  - Else y_dest>Y_cord -> N; y_dest<Y_cord -> S.
  - Else -> PE.
- Drop rule: x_dest>=MESH_SIZE or y_dest>=MESH_SIZE -> head popped without arbitration, o_drop=1 for that cycle.
- Arbitration, per output independently:
  - Requesters are valid heads routed there. Grant the first requester scanning ptr+1, ptr+2, ... modulo 5.
  - Grant only if the output register can load (!o_valid | o_ready); the granted head pops the same cycle.
  - ptr updates to the granted index only on grant.
- Output register: o_valid/o_data registered. o_data holds stable while o_valid&!o_ready. Register accepts a new flit in the same cycle the old one leaves.
- Latency: accepted on edge 0; arbitrated in the following cycle; o_valid high after edge 1, i.e. 2 cycles with no contention.
- Flit order preserved per input->output pair. A blocked head blocks its FIFO (head-of-line, no bypass).
- FIFO pointers wrap at FIFO_DEPTH; occupancy counter is log2(FIFO_DEPTH)+1 bits.

Optional Feature:
- Macro ROUTER_STATS_EN.
- Defined: adds output port o_flit_cnt (5*16 bits), per-output saturating counters incremented on each o_valid&o_ready, plus o_drop_cnt (16 bits); all cleared by rst_n.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package noc_pkg: port index constants (PORT_N..PORT_PE, NUM_PORTS=5), flit field offset functions, route-direction encoding.
- Sub-module router_input_fifo (parametrised FLIT_W, FIFO_DEPTH; push/pop/full/empty/head), instantiated 5x.
- Arbiter and route logic stay inline.

Test Plan (MESH_SIZE=4, ADDR_WIDTH=2, X_cord=1, Y_cord=1, FIFO_DEPTH=4):
- PE sends {2,1,16'hAAAA}, all o_ready=1 -> o_valid[E]=1 exactly 2 cycles after acceptance, o_data[E]=that flit; no other o_valid.
- N, S, W each send one flit dest (1,1) in the same cycle -> PE outputs S, W, N payloads in order S(1), W(3), N(0) after reset ptr=4? No: after reset ptr=4, so order is N(0), S(1), W(3), on consecutive cycles.
- o_ready[W]=0, W-bound flits {0,1,k} pushed on E for 6 cycles -> 1 in output register, 4 in FIFO, i_ready[E]=0 from 6th attempt; release -> 5 flits delivered in order, 1 rejected.
- Input E sends {3,0,16'h1234} (x_dest in-range, y_dest in-range) -> routed E; then {1,3,...} -> N; {1,0,...} -> S.
- MESH_SIZE=3 build, flit {3,1,16'hDEAD} -> no o_valid, o_drop pulses one cycle.
- rst_n=0 while 3 flits buffered -> next cycle all o_valid=0, i_ready=0; after release i_ready=5'b11111, no stale flits emerge.
